// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the dmem_ctrl port seen by dmem_arbiter.
// The slave modport is the arbiter's view; master is the environment side (requesters + memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [2:0]        m0_memop, m1_memop;
    logic              m0_ack,   m1_ack;
    logic              m0_err,   m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [2:0]        mem_memop;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dataout;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_memop, m1_memop, mem_dataout,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_addr, mem_datain, mem_memop, mem_we
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_memop, m1_memop, mem_dataout,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_addr, mem_datain, mem_memop, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of dmem_ctrl: latch, access, wait read latency, ack.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              grant, grant_nxt;   // 0 = m0, 1 = m1
    logic              we_q;
    logic              any_req;
    logic              win_we;
    logic              win_err;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [2:0]        win_memop;
`ifdef DMEM_ARB_RR_EN
    logic              prio_m1;
`endif

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        any_req   = bus.m0_req || bus.m1_req;
        if (state == IDLE && any_req) begin
`ifdef DMEM_ARB_RR_EN
            grant_nxt = bus.m1_req && (!bus.m0_req || prio_m1);
`else
            grant_nxt = !bus.m0_req;
`endif
        end
        win_we    = grant_nxt ? bus.m1_we    : bus.m0_we;
        win_addr  = grant_nxt ? bus.m1_addr  : bus.m0_addr;
        win_wdata = grant_nxt ? bus.m1_wdata : bus.m0_wdata;
        win_memop = grant_nxt ? bus.m1_memop : bus.m0_memop;
        win_err   = misaligned(win_memop, win_addr[1:0]);
        case (state)
            IDLE:    if (any_req) state_nxt = win_err ? DONE : ACCESS;
            ACCESS:  state_nxt = we_q ? DONE : RDWAIT;
            RDWAIT:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each lines up with the state it belongs to;
    // an IDLE->DONE transition is by construction the error path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant          <= 1'b0;
            we_q           <= 1'b0;
            bus.m0_ack     <= 1'b0;
            bus.m1_ack     <= 1'b0;
            bus.m0_err     <= 1'b0;
            bus.m1_err     <= 1'b0;
            bus.m0_rdata   <= '0;
            bus.m1_rdata   <= '0;
            bus.mem_addr   <= '0;
            bus.mem_datain <= '0;
            bus.mem_memop  <= '0;
            bus.mem_we     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            prio_m1        <= 1'b0;
`endif
        end else begin
            bus.mem_we <= (state_nxt == ACCESS) && win_we;
            bus.m0_ack <= (state_nxt == DONE) && !grant_nxt;
            bus.m1_ack <= (state_nxt == DONE) &&  grant_nxt;
            bus.m0_err <= (state_nxt == DONE) && !grant_nxt && (state == IDLE);
            bus.m1_err <= (state_nxt == DONE) &&  grant_nxt && (state == IDLE);
            if (state == IDLE && state_nxt != IDLE) begin
                grant <= grant_nxt;
                we_q  <= win_we;
`ifdef DMEM_ARB_RR_EN
                prio_m1 <= !grant_nxt;
`endif
            end
            if (state_nxt == ACCESS) begin
                bus.mem_addr   <= win_addr;
                bus.mem_datain <= win_wdata;
                bus.mem_memop  <= win_memop;
            end
            if (state == RDWAIT) begin
                if (grant) bus.m1_rdata <= bus.mem_dataout;
                else       bus.m0_rdata <= bus.mem_dataout;
            end
            if (state == IDLE && state_nxt == DONE) begin
                if (grant_nxt) bus.m1_rdata <= '0;
                else           bus.m0_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, random traffic against a byte-level model,
// plus reset, contention and mid-read-reset sequences. Works with or without DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    localparam int ADDR_W = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();
    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // dmem_ctrl stand-in: word storage, registered read with extension
    logic [31:0] words [0:255] = '{default: '0};

    function automatic logic [31:0] env_read(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        case (op)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return w;
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.mem_dataout <= env_read(words[bus.mem_addr[9:2]], bus.mem_addr[1:0], bus.mem_memop);
        if (bus.mem_we) begin
            case (bus.mem_memop[1:0])
                2'b00:   words[bus.mem_addr[9:2]][{bus.mem_addr[1:0], 3'b000} +: 8]  <= bus.mem_datain[7:0];
                2'b01:   words[bus.mem_addr[9:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_datain[15:0];
                default: words[bus.mem_addr[9:2]] <= bus.mem_datain;
            endcase
        end
    end

    // Reference model: flat byte memory, arithmetic extraction
    logic [7:0]  ref_mem [0:1023] = '{default: '0};
    logic [31:0] last_rd [2];
    int          rr_last = 1;

    function automatic bit model_err(input logic [2:0] op, input int addr);
        if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b1;
        return (addr % (1 << op[1:0])) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input int addr);
        longint v = 0;
        int n = 1 << op[1:0];
        for (int k = 0; k < n; k++) v += longint'(ref_mem[(addr + k) % 1024]) << (8 * k);
        if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic void model_store(input logic [2:0] op, input int addr, input logic [31:0] wd);
        int n = 1 << op[1:0];
        for (int k = 0; k < n; k++) ref_mem[(addr + k) % 1024] = 8'(wd >> (8 * k));
    endfunction

    function automatic int model_winner(input int r0, input int r1);
`ifdef DMEM_ARB_RR_EN
        if (r0 > 0 && r1 > 0) return (rr_last == 0) ? 1 : 0;
`endif
        return (r0 > 0) ? 0 : 1;
    endfunction

    task automatic set_req(input int m, input logic we, input logic [17:0] addr,
                           input logic [31:0] wd, input logic [2:0] op);
        if (m == 0) begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_memop = op; bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_memop = op; bus.m1_req = 1'b1;
        end
    endtask

    // One transaction from the first IDLE cycle; cycle numbers count that IDLE cycle as 1
    task automatic do_txn(input string tag, input int m, input logic we, input logic [17:0] addr,
                          input logic [31:0] wd, input logic [2:0] op, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_cyc);
        int n = 0;
        bit got = 0;
        bit other = 0;
        int we_cnt = 0;
        int we_cyc = 0;
        logic [17:0] we_addr = '0;
        @(posedge clk); #1;
        chk({tag, "_ack_idle"}, {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        set_req(m, we, addr, wd, op);
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_we) begin we_cnt++; we_cyc = n + 1; we_addr = bus.mem_addr; end
            if (m == 0 ? bus.m1_ack : bus.m0_ack) other = 1;
            if (m == 0 ? bus.m0_ack : bus.m1_ack) got = 1;
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        chk({tag, "_ack_cycle"}, got ? n + 1 : 999, exp_cyc);
        chk({tag, "_err"}, {31'h0, (m == 0 ? bus.m0_err : bus.m1_err)}, {31'h0, exp_err});
        chk({tag, "_rdata"}, (m == 0 ? bus.m0_rdata : bus.m1_rdata), exp_rd);
        chk({tag, "_we_count"}, we_cnt, (we && !exp_err) ? 1 : 0);
        chk({tag, "_other_ack"}, {31'h0, other}, 32'h0);
        if (we && !exp_err) begin
            chk({tag, "_we_cycle"}, we_cyc, 2);
            chk({tag, "_we_addr"}, {14'h0, we_addr}, {14'h0, addr});
            model_store(op, int'(addr), wd);
        end
        last_rd[m] = exp_rd;
        rr_last = m;
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        err;
        logic [31:0] rd;
        int          cyc;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m1_seen;
        int first;
        int q_got [$];
        int q_exp [$];
        int r0, r1, c0, c1, w;

        vecs[0]  = '{0, 1'b1, 18'h10, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        3};
        vecs[1]  = '{0, 1'b0, 18'h10, 32'h0,        3'd2, 1'b0, 32'hDEADBEEF, 4};
        vecs[2]  = '{1, 1'b1, 18'h10, 32'h80FF0102, 3'd2, 1'b0, 32'h0,        3};
        vecs[3]  = '{1, 1'b0, 18'h13, 32'h0,        3'd0, 1'b0, 32'hFFFFFF80, 4};
        vecs[4]  = '{1, 1'b0, 18'h13, 32'h0,        3'd4, 1'b0, 32'h00000080, 4};
        vecs[5]  = '{0, 1'b0, 18'h02, 32'h0,        3'd2, 1'b1, 32'h0,        2};
        vecs[6]  = '{0, 1'b0, 18'h10, 32'h0,        3'd2, 1'b0, 32'h80FF0102, 4};
        vecs[7]  = '{1, 1'b0, 18'h12, 32'h0,        3'd1, 1'b0, 32'hFFFF80FF, 4};
        vecs[8]  = '{1, 1'b0, 18'h12, 32'h0,        3'd5, 1'b0, 32'h000080FF, 4};
        vecs[9]  = '{0, 1'b0, 18'h11, 32'h0,        3'd1, 1'b1, 32'h0,        2};
        vecs[10] = '{1, 1'b1, 18'h12, 32'h12345678, 3'd2, 1'b1, 32'h0,        2};
        vecs[11] = '{0, 1'b1, 18'h11, 32'h00000055, 3'd0, 1'b0, 32'h0,        3};
        vecs[12] = '{0, 1'b0, 18'h10, 32'h0,        3'd2, 1'b0, 32'h80FF5502, 4};
        vecs[13] = '{1, 1'b0, 18'h10, 32'h0,        3'd3, 1'b1, 32'h0,        2};
        vecs[14] = '{0, 1'b1, 18'h14, 32'hFFFFFFFF, 3'd2, 1'b0, 32'h0,        3};
        vecs[15] = '{0, 1'b1, 18'h16, 32'h1234ABCD, 3'd1, 1'b0, 32'h0,        3};
        vecs[16] = '{1, 1'b0, 18'h14, 32'h0,        3'd2, 1'b0, 32'hABCDFFFF, 4};
        vecs[17] = '{0, 1'b0, 18'h17, 32'h0,        3'd6, 1'b1, 32'h0,        2};

        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_memop = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_memop = '0;

        // Reset with both requesting
        set_req(0, 1'b0, 18'h10, 32'h0, 3'd2);
        set_req(1, 1'b0, 18'h14, 32'h0, 3'd2);
        w = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.mem_we) w++;
        end
        chk("rst_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        chk("rst_err", {30'h0, bus.m1_err, bus.m0_err}, 32'h0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
        chk("rst_mem_addr", {14'h0, bus.mem_addr}, 32'h0);
        chk("rst_mem_datain", bus.mem_datain, 32'h0);
        chk("rst_mem_memop", {29'h0, bus.mem_memop}, 32'h0);
        chk("rst_mem_we_cycles", w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        m1_seen = 0;
        for (int i = 0; i < 20 && !m1_seen; i++) begin
            @(posedge clk); #1;
            if (first < 0 && bus.m0_ack) first = 0;
            if (first < 0 && bus.m1_ack) first = 1;
            if (bus.m0_ack) bus.m0_req = 1'b0;
            if (bus.m1_ack) begin bus.m1_req = 1'b0; m1_seen = 1; end
        end
        chk("rst_first_grant", first, 0);
        chk("rst_m1_served", {31'h0, m1_seen}, 32'h1);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        rr_last = 1;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            logic [31:0] exp_rd;
            exp_rd = (vecs[i].we && !vecs[i].err) ? last_rd[vecs[i].m] : vecs[i].rd;
            do_txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].op, vecs[i].err, exp_rd, vecs[i].cyc);
        end

        // Random single-master traffic against the model
        for (int i = 0; i < 150; i++) begin
            int m, addr;
            logic [2:0] op;
            logic we, e;
            logic [31:0] wd, rd;
            m = $urandom_range(0, 1);
            addr = $urandom_range(0, 63);
            wd = $urandom;
            case ($urandom_range(0, 9))
                0:       op = 3'd3 + 3'($urandom_range(0, 1)) * 3'd3 + 3'($urandom_range(0, 1));
                1, 2:    op = 3'd4 + 3'($urandom_range(0, 1));
                default: op = 3'($urandom_range(0, 2));
            endcase
            we = (op[2] == 1'b0 && op[1:0] != 2'b11) && ($urandom_range(0, 2) == 0);
            e = model_err(op, addr);
            rd = e ? 32'h0 : (we ? last_rd[m] : model_load(op, addr));
            do_txn($sformatf("rnd%0d", i), m, we, 18'(addr), wd, op, e, rd, e ? 2 : (we ? 3 : 4));
        end

        // Contention: both hold req for 4 transactions each
        r0 = 4; r1 = 4;
        while (r0 + r1 > 0) begin
            w = model_winner(r0, r1);
            q_exp.push_back(w);
            if (w == 0) r0--; else r1--;
            rr_last = w;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 18'h10, 32'h0, 3'd2);
        set_req(1, 1'b0, 18'h14, 32'h0, 3'd2);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 100 && q_got.size() < 8; i++) begin
            @(posedge clk); #1;
            if (bus.m0_ack) begin q_got.push_back(0); c0++; if (c0 == 4) bus.m0_req = 1'b0; end
            if (bus.m1_ack) begin q_got.push_back(1); c1++; if (c1 == 4) bus.m1_req = 1'b0; end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("cont_order%0d", i), (i < q_got.size()) ? q_got[i] : 32'hFFFFFFFF, q_exp[i]);
        chk("cont_m0_rdata", bus.m0_rdata, model_load(3'd2, 'h10));
        chk("cont_m1_rdata", bus.m1_rdata, model_load(3'd2, 'h14));
        last_rd[0] = model_load(3'd2, 'h10);
        last_rd[1] = model_load(3'd2, 'h14);

        // Reset during RDWAIT of an m1 load
        @(posedge clk); #1;
        set_req(1, 1'b0, 18'h14, 32'h0, 3'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.m1_req = 1'b0;
        m1_seen = 0;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.m1_ack) m1_seen = 1;
            if (bus.mem_we) w++;
            @(posedge clk);
        end
        #1;
        chk("midrst_no_ack", {31'h0, m1_seen}, 32'h0);
        chk("midrst_mem_we", w, 0);
        chk("midrst_m1_rdata", bus.m1_rdata, 32'h0);
        chk("midrst_mem_addr", {14'h0, bus.mem_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        rr_last = 1;
        do_txn("post_rst_load", 0, 1'b0, 18'h10, 32'h0, 3'd2, 1'b0, model_load(3'd2, 'h10), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
